// File: rtl/tmds_decode.sv
// Receive-side TMDS channel decoder: recovers the word boundary from control
// tokens (requesting bitslips while searching) and decodes 10-bit symbols.
module tmds_decode #(
   parameter int LOCK_CNT   = 16,
   parameter int SEARCH_TMO = 1024,
   parameter int SLIP_WAIT  = 16,
   parameter int CNT_W      = 11
) (
   input  logic       sys_clk,
   input  logic       sys_rst_n,
   input  logic [9:0] tmds_in,
   output logic       bitslip,
   output logic       locked,
   output logic       de,
   output logic       c0,
   output logic       c1,
   output logic [7:0] data_out,
   output logic       token_err
);

   localparam int TR_W = $clog2(LOCK_CNT + 1);
   localparam int WT_W = $clog2(SLIP_WAIT + 1);
   localparam logic [TR_W-1:0]  TR_LIM  = TR_W'(LOCK_CNT - 1);
   localparam logic [CNT_W-1:0] TMO_LIM = CNT_W'(SEARCH_TMO - 1);
   localparam logic [WT_W-1:0]  WT_LIM  = WT_W'(SLIP_WAIT - 1);

   typedef enum logic [1:0] {
      ST_SEARCH = 2'd0,
      ST_SLIP   = 2'd1,
      ST_WAIT   = 2'd2,
      ST_LOCKED = 2'd3
   } state_t;

   // Returns {is_token, c1, c0}.
   function automatic logic [2:0] tok_detect(input logic [9:0] w);
      logic [2:0] r;
      case (w)
         10'b1101010100: r = 3'b100;
         10'b0010101011: r = 3'b101;
         10'b0101010100: r = 3'b110;
         10'b1010101011: r = 3'b111;
         default:        r = 3'b000;
      endcase
      return r;
   endfunction

   function automatic logic [7:0] tmds_dec(input logic [9:0] w);
      logic [7:0] d;
      logic [7:0] o;
      d    = w[9] ? ~w[7:0] : w[7:0];
      o[0] = d[0];
      for (int i = 1; i < 8; i++) begin
         o[i] = w[8] ? (d[i] ^ d[i-1]) : ~(d[i] ^ d[i-1]);
      end
      return o;
   endfunction

   logic [9:0]       w_r;
   logic             is_tok_r;
   logic [1:0]       tok_r;
   logic [2:0]       det_s;
   logic [7:0]       dec_s;
   state_t           state_r, state_s;
   logic [TR_W-1:0]  tok_run_r, tok_run_s;
   logic [CNT_W-1:0] tmo_r, tmo_s;
   logic [WT_W-1:0]  wcnt_r, wcnt_s;
   logic             bitslip_r, locked_r, de_r, c0_r, c1_r, token_err_r;
   logic [7:0]       data_r;

   assign det_s = tok_detect(tmds_in);
   assign dec_s = tmds_dec(w_r);

   // Stage 1: capture the word and classify it.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         w_r      <= 10'd0;
         is_tok_r <= 1'b0;
         tok_r    <= 2'b00;
      end else begin
         w_r      <= tmds_in;
         is_tok_r <= det_s[2];
         tok_r    <= det_s[1:0];
      end
   end

   // Alignment FSM state and counters.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state_r   <= ST_SEARCH;
         tok_run_r <= '0;
         tmo_r     <= '0;
         wcnt_r    <= '0;
      end else begin
         state_r   <= state_s;
         tok_run_r <= tok_run_s;
         tmo_r     <= tmo_s;
         wcnt_r    <= wcnt_s;
      end
   end

   // Next state; every limit triggers a transition, so counters never wrap.
   always_comb begin
      state_s   = state_r;
      tok_run_s = tok_run_r;
      tmo_s     = tmo_r;
      wcnt_s    = wcnt_r;
      case (state_r)
         ST_SEARCH: begin
            if (is_tok_r) begin
               tmo_s = '0;
               if (tok_run_r >= TR_LIM) begin
                  state_s   = ST_LOCKED;
                  tok_run_s = '0;
               end else begin
                  tok_run_s = tok_run_r + 1'b1;
               end
            end else begin
               tok_run_s = '0;
               if (tmo_r >= TMO_LIM) begin
                  state_s = ST_SLIP;
                  tmo_s   = '0;
               end else begin
                  tmo_s = tmo_r + 1'b1;
               end
            end
         end
         ST_SLIP: begin
            state_s = ST_WAIT;
            wcnt_s  = '0;
         end
         ST_WAIT: begin
            if (wcnt_r >= WT_LIM) begin
               state_s   = ST_SEARCH;
               wcnt_s    = '0;
               tok_run_s = '0;
               tmo_s     = '0;
            end else begin
               wcnt_s = wcnt_r + 1'b1;
            end
         end
         ST_LOCKED: begin
            if (is_tok_r) begin
               tmo_s = '0;
            end else if (tmo_r >= TMO_LIM) begin
               state_s   = ST_SEARCH;
               tmo_s     = '0;
               tok_run_s = '0;
            end else begin
               tmo_s = tmo_r + 1'b1;
            end
         end
         default: begin
            state_s   = ST_SEARCH;
            tok_run_s = '0;
            tmo_s     = '0;
            wcnt_s    = '0;
         end
      endcase
   end

   // Stage 2: registered outputs, forced quiet while unaligned.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         bitslip_r   <= 1'b0;
         locked_r    <= 1'b0;
         de_r        <= 1'b0;
         c0_r        <= 1'b0;
         c1_r        <= 1'b0;
         data_r      <= 8'h00;
         token_err_r <= 1'b0;
      end else begin
         bitslip_r   <= (state_s == ST_SLIP);
         locked_r    <= (state_r == ST_LOCKED);
         token_err_r <= (state_r == ST_LOCKED) && !is_tok_r && !de_r;
         if (state_r != ST_LOCKED) begin
            de_r   <= 1'b0;
            c0_r   <= 1'b0;
            c1_r   <= 1'b0;
            data_r <= 8'h00;
         end else if (is_tok_r) begin
            de_r   <= 1'b0;
            c1_r   <= tok_r[1];
            c0_r   <= tok_r[0];
            data_r <= 8'h00;
         end else begin
            de_r   <= 1'b1;
            data_r <= dec_s;
         end
      end
   end

   assign bitslip   = bitslip_r;
   assign locked    = locked_r;
   assign de        = de_r;
   assign c0        = c0_r;
   assign c1        = c1_r;
   assign data_out  = data_r;
   assign token_err = token_err_r;

endmodule
